piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001: Parameter N SHALL be defined as: N, default 8, word width in bits; legal range N >= 2.
REQ-002: Port clk SHALL be defined as: clk  input  1  single clock; all state updates on its rising edge.
REQ-003: Port reset SHALL be defined as: reset  input  1  reset, asynchronous and active-high.
REQ-004: Port data_in SHALL be defined as: data_in  input  N  parallel word offered for serialization.
REQ-005: Port load_valid SHALL be defined as: load_valid  input  1  data_in valid this cycle.
REQ-006: Port load_ready SHALL be defined as: load_ready  output  1  block can accept a word this cycle.
REQ-007: Port serial_out SHALL be defined as: serial_out  output  1  serial bit stream, LSB first; feeds the downstream shift register's serial_in.
REQ-008: Port frame SHALL be defined as: frame  output  1  serial_out carries a valid data bit this cycle.
REQ-009: Port last_bit SHALL be defined as: last_bit  output  1  serial_out carries bit N-1 of the current word.

Function
REQ-010: A word SHALL be accepted on a rising edge where load_valid=1 and load_ready=1; load_valid without load_ready SHALL have no effect.
REQ-011: The block SHALL contain an N-bit shift register, a bit counter of width clog2(N), a one-word holding register with a full flag, and a two-state FSM: IDLE and SHIFT.
REQ-012: load_ready SHALL equal NOT hold_full (combinational), independent of FSM state.
REQ-013: IDLE + accept: shreg <= data_in, cnt <= 0, state -> SHIFT.
REQ-014: SHIFT with cnt < N-1: shreg shifts right one position, cnt increments; an accepted word SHALL be written to the holding register, setting hold_full.
REQ-015: SHIFT with cnt = N-1 and hold_full=1: shreg <= hold, hold_full <= 0, cnt <= 0, stay SHIFT; this SHALL give no gap cycle between words.
REQ-016: SHIFT with cnt = N-1, hold_full=0, and a word accepted on the same edge: the word SHALL bypass the holding register into shreg, cnt <= 0, stay SHIFT.
REQ-017: SHIFT with cnt = N-1, hold_full=0, and no accept: state -> IDLE.
REQ-018: serial_out SHALL equal shreg[0] while frame=1 and SHALL be 0 while frame=0.
REQ-019: frame SHALL be 1 exactly when state = SHIFT; last_bit SHALL be 1 exactly when state = SHIFT and cnt = N-1.
REQ-020: Latency: bit 0 of an accepted word SHALL appear on serial_out in the cycle following the accepting edge when IDLE; each word SHALL occupy exactly N consecutive frame cycles.
REQ-021: After a word's N frame cycles, a downstream right-shift register of width N taking serial_out into its MSB SHALL hold that word exactly.
REQ-022: At most one word SHALL be accepted per edge; with hold_full=1, no word SHALL be accepted until the REQ-015 transfer edge.

Reset
REQ-023: While reset=1, and immediately on its assertion regardless of clk, the outputs SHALL be: state=IDLE, shreg=0, cnt=0, hold=0, hold_full=0, serial_out=0, frame=0, last_bit=0, load_ready=1.
REQ-024: Reset asserted mid-frame SHALL discard the in-flight word and any held word; the next word SHALL start cleanly at bit 0 after deassertion.
REQ-025: No word SHALL be accepted on an edge where reset=1.

Structure
REQ-026: A shared package SHALL hold the FSM state type (IDLE, SHIFT) and the counter-width constant function clog2.
REQ-027: The N-bit shift register SHALL be one sub-module, piso_shift_core, providing parallel load, shift-right enable, and shreg[0] output; the FSM, counter and holding register SHALL stay in piso_serializer.

Verification
REQ-028: Reset check: assert reset mid-frame, off-edge -> serial_out, frame and last_bit go to 0 and load_ready goes to 1 without waiting for a clk edge; the next word serializes from bit 0.
REQ-029: Single word: N=8, load 8'hA5 from IDLE -> serial_out = 1,0,1,0,0,1,0,1 over 8 cycles starting the cycle after accept; last_bit high in cycle 8 only; frame drops in cycle 9.
REQ-030: Back-to-back: load 8'h3C, then 8'hC3 during shifting -> load_ready=0 after the second accept; 16 contiguous frame cycles with no gap; load_ready returns to 1 at the transfer edge.
REQ-031: Bypass: offer 8'hFF first at the edge where last_bit=1 and hold is empty -> accepted directly; the next cycle shows bit 0 of 8'hFF with no idle cycle.
REQ-032: Loopback: drive serial_out into the N=8 downstream shift register -> it holds 8'h5A after the frame of 8'h5A completes.
REQ-033: Backpressure: keep load_valid=1 with random data across 4 words -> each word is accepted exactly once in order, and no accept happens while load_ready=0.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared types and constant helpers for the parallel-in serial-out serializer.
package piso_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bits needed to count 0..n-1; never less than one so a counter always exists.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 32'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/piso_shift_core.sv
// N-bit right-shift register with parallel load; bit 0 is the serial tap.
module piso_shift_core #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         shift_en,
    output logic         lsb
);

    logic [N-1:0] shreg;

    // Parallel load wins over shift; shifting brings zeros in from the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= load_data;
        end else if (shift_en) begin
            shreg <= {1'b0, shreg[N-1:1]};
        end
    end

    assign lsb = shreg[0];

endmodule

// File: rtl/piso_serializer.sv
// Word-to-bit serializer, LSB first, with a one-word skid so words run back to back.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         serial_out,
    output logic         frame,
    output logic         last_bit
);

    localparam int unsigned   CW       = clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t       state;
    state_t       state_nxt;
    logic [CW-1:0] cnt;
    logic [N-1:0] hold;
    logic         hold_full;
    logic         accept;
    logic         core_load;
    logic         core_shift;
    logic         load_sel_hold;
    logic         cnt_clr;
    logic         cnt_inc;
    logic         hold_wr;
    logic         hold_take;
    logic         core_lsb;

    // Ready only reflects the skid slot, so a word can be taken in any state.
    assign load_ready = ~hold_full;
    assign accept     = load_valid & load_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave SHIFT only when the last bit goes out with nothing queued.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if ((cnt == CNT_LAST) && !hold_full && !accept) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath strobes and framing outputs decoded from state and counter.
    always_comb begin
        core_load     = 1'b0;
        core_shift    = 1'b0;
        load_sel_hold = 1'b0;
        cnt_clr       = 1'b0;
        cnt_inc       = 1'b0;
        hold_wr       = 1'b0;
        hold_take     = 1'b0;
        frame         = 1'b0;
        last_bit      = 1'b0;
        serial_out    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    core_load = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
            SHIFT: begin
                frame      = 1'b1;
                last_bit   = (cnt == CNT_LAST);
                serial_out = core_lsb;
                if (cnt != CNT_LAST) begin
                    core_shift = 1'b1;
                    cnt_inc    = 1'b1;
                    hold_wr    = accept;
                end else if (hold_full) begin
                    core_load     = 1'b1;
                    load_sel_hold = 1'b1;
                    hold_take     = 1'b1;
                    cnt_clr       = 1'b1;
                end else begin
                    // Bypass straight into the shifter if a word arrives now.
                    core_load = accept;
                    cnt_clr   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Bit counter and skid register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CW'(1);
            end
            if (hold_wr) begin
                hold      <= data_in;
                hold_full <= 1'b1;
            end else if (hold_take) begin
                hold_full <= 1'b0;
            end
        end
    end

    piso_shift_core #(
        .N (N)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (core_load),
        .load_data (load_sel_hold ? hold : data_in),
        .shift_en  (core_shift),
        .lsb       (core_lsb)
    );

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer with N=8 and a downstream loopback register.
module tb_piso_serializer;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       load_valid;
    logic       load_ready;
    logic       serial_out;
    logic       frame;
    logic       last_bit;

    logic [7:0] ds;
    int         n_cmp;
    int         n_bad;

    piso_serializer #(.N(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .serial_out (serial_out),
        .frame      (frame),
        .last_bit   (last_bit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream right-shift register fed MSB-first from serial_out during frames.
    initial ds = 8'h00;
    always @(posedge clk) begin
        if (frame) ds <= {serial_out, ds[7:1]};
    end

    // Hard stop in case something wedges.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_line(input string tag, input logic so, input logic fr, input logic lb);
        chk({tag, "_so"}, 32'(serial_out), 32'(so));
        chk({tag, "_fr"}, 32'(frame), 32'(fr));
        chk({tag, "_lb"}, 32'(last_bit), 32'(lb));
    endtask

    initial begin
        logic [7:0]  w8;
        logic [15:0] w16;
        logic [7:0]  words [4];
        bit          exp_bits [$];
        int          acc_cyc [$];
        int          acc_tbl [4];
        int          nframe;
        logic        acc;

        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        load_valid = 1'b0;
        data_in    = 8'h00;

        // Reset state before any clock edge.
        #3;
        chk_line("rst0", 1'b0, 1'b0, 1'b0);
        chk("rst0_rdy", 32'(load_ready), 32'd1);
        tick();
        reset = 1'b0;
        tick();

        // Single word A5 from IDLE.
        w8 = 8'hA5;
        data_in = w8;
        load_valid = 1'b1;
        chk("a5_rdy", 32'(load_ready), 32'd1);
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_line("a5", w8[i], 1'b1, (i == 7));
            tick();
        end
        chk_line("a5_end", 1'b0, 1'b0, 1'b0);
        chk("a5_ds", 32'(ds), 32'h0000_00A5);

        // Back-to-back 3C then C3 through the skid slot.
        w16 = 16'hC33C;
        data_in = 8'h3C;
        load_valid = 1'b1;
        tick();
        chk_line("b2b_k1", w16[0], 1'b1, 1'b0);
        chk("b2b_k1_rdy", 32'(load_ready), 32'd1);
        data_in = 8'hC3;
        tick();
        load_valid = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            chk_line("b2b", w16[k-1], 1'b1, (k == 8) || (k == 16));
            chk("b2b_rdy", 32'(load_ready), 32'(k >= 9));
            if (k == 9) chk("b2b_ds0", 32'(ds), 32'h0000_003C);
            tick();
        end
        chk_line("b2b_end", 1'b0, 1'b0, 1'b0);
        chk("b2b_ds1", 32'(ds), 32'h0000_00C3);

        // Loopback of 5A, then FF offered on the last_bit cycle bypasses the skid.
        w16 = 16'hFF5A;
        data_in = 8'h5A;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            chk_line("byp", w16[k-1], 1'b1, (k == 8) || (k == 16));
            if (k == 8) begin
                chk("byp_rdy", 32'(load_ready), 32'd1);
                data_in = 8'hFF;
                load_valid = 1'b1;
            end
            if (k == 9) chk("loop_5a", 32'(ds), 32'h0000_005A);
            tick();
            if (k == 8) load_valid = 1'b0;
        end
        chk_line("byp_end", 1'b0, 1'b0, 1'b0);
        chk("byp_ds", 32'(ds), 32'h0000_00FF);

        // Mid-frame reset with a word in the skid, asserted between edges.
        data_in = 8'h96;
        load_valid = 1'b1;
        tick();
        data_in = 8'h11;
        tick();
        load_valid = 1'b0;
        chk("mid_rdy_full", 32'(load_ready), 32'd0);
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk_line("mid_rst", 1'b0, 1'b0, 1'b0);
        chk("mid_rst_rdy", 32'(load_ready), 32'd1);
        data_in = 8'hEE;
        load_valid = 1'b1;
        tick();
        chk("rst_noacc_fr", 32'(frame), 32'd0);
        load_valid = 1'b0;
        reset = 1'b0;
        tick();
        chk("post_rst_fr", 32'(frame), 32'd0);
        w8 = 8'h81;
        data_in = w8;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_line("rec", w8[i], 1'b1, (i == 7));
            tick();
        end
        chk_line("rec_end", 1'b0, 1'b0, 1'b0);
        chk("rec_ds", 32'(ds), 32'h0000_0081);

        // Backpressure: load_valid held high across four random words.
        acc_tbl = '{0, 1, 9, 17};
        for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
        nframe = 0;
        data_in = words[0];
        load_valid = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (frame) begin
                nframe++;
                if (exp_bits.size() == 0) chk("bp_extra", 32'd1, 32'd0);
                else chk("bp_bit", 32'(serial_out), 32'(exp_bits.pop_front()));
            end
            acc = load_valid && load_ready;
            if (acc) begin
                for (int b = 0; b < 8; b++) exp_bits.push_back(data_in[b]);
                acc_cyc.push_back(cyc);
            end
            tick();
            if (acc) begin
                if (acc_cyc.size() < 4) data_in = words[acc_cyc.size()];
                else load_valid = 1'b0;
            end
        end
        chk("bp_nacc", 32'(acc_cyc.size()), 32'd4);
        chk("bp_nframe", 32'(nframe), 32'd32);
        chk("bp_left", 32'(exp_bits.size()), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("bp_acc_cyc", (i < acc_cyc.size()) ? 32'(acc_cyc[i]) : 32'hFFFF_FFFF, 32'(acc_tbl[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
